pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The unit SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 32'hBFC0_0000, is the PC value loaded by reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  pipeline stall; blocks issue of a new fetch request.
REQ-006 jump_en  input  1  jump redirect valid this cycle.
REQ-007 jump_target  input  32  jump target, already concatenated as {PC[31:28], index, 2'b00}.
REQ-008 branch_en  input  1  branch-taken redirect valid this cycle.
REQ-009 branch_target  input  32  branch target address.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  32  fetch address; equals pc while imem_req=1.
REQ-012 imem_ack  input  1  memory accepts and completes the current request; ignored when imem_req=0.
REQ-013 pc  output  32  current PC register.
REQ-014 pc_plus4  output  32  pc + 4, combinational, 32-bit wrap.
REQ-015 inst_valid  output  1  one-cycle pulse marking a completed fetch.
REQ-016 fetch_pc  output  32  address of the fetch completed, valid with inst_valid.
REQ-017 misalign  output  1  one-cycle pulse when the accepted redirect target has bits[1:0] != 0.

Function
REQ-018 The FSM SHALL have the states BOOT, IDLE and REQ, encoded as 2 bits.
REQ-019 BOOT is entered on reset and lasts exactly one cycle; its next state is IDLE if stall=1, else REQ.
REQ-020 IDLE: imem_req=0; next state is REQ when stall=0.
REQ-021 REQ: imem_req=1 and imem_addr=pc; imem_req and imem_addr SHALL stay stable until the imem_ack cycle, regardless of stall or redirects.
REQ-022 REQ with imem_ack=1: on that edge, pc <= next_pc, fetch_pc <= old pc, inst_valid=1 for the following cycle; next state is REQ if stall=0, else IDLE.
REQ-023 Redirect priority SHALL be jump_en over branch_en over the pending redirect over pc+4.
REQ-024 A redirect in REQ without imem_ack SHALL be latched into a pending register (pend_valid, pend_target); a later redirect overwrites it.
REQ-025 next_pc on the ack cycle is the same-cycle redirect if present, else pend_target if pend_valid, else pc+4; pend_valid clears on that edge.
REQ-026 A redirect in BOOT or IDLE SHALL load pc directly on the next edge and clear pend_valid.
REQ-027 The redirect target SHALL have bits[1:0] forced to 2'b00 when loaded; if the raw bits were nonzero, misalign pulses for one cycle in the cycle after the target is accepted (latched or loaded).
REQ-028 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without a flag.
REQ-029 stall SHALL never abort an outstanding request; it only gates entry into REQ.
REQ-030 Back-to-back acks in consecutive cycles SHALL each produce an inst_valid pulse, with no gaps.

Reset
REQ-031 While rst_n=0: state=BOOT, pc=RESET_PC, fetch_pc=RESET_PC, pend_valid=0, imem_req=0, inst_valid=0, misalign=0.
REQ-032 Reset asserted mid-request SHALL drop imem_req immediately (asynchronously) and discard pending redirects.
REQ-033 The first imem_req SHALL assert in the second cycle after rst_n deasserts, provided stall=0.

Verification
REQ-034 Reset release, stall=0, ack every cycle -> imem_addr sequence BFC00000, BFC00004, BFC00008; inst_valid pulses with fetch_pc one fetch behind.
REQ-035 In REQ at pc=BFC00010, ack delayed 3 cycles, with jump_en=1 target=80001000 in the first wait cycle -> imem_addr holds BFC00010 until ack; next request goes to 80001000.
REQ-036 jump_en=1 (00400000) and branch_en=1 (00500000) in the same ack cycle -> next pc=00400000.
REQ-037 stall=1 asserted during an outstanding request -> request completes on ack; FSM goes to IDLE, imem_req=0 until stall=0, pc unchanged while in IDLE.
REQ-038 branch_target=00400006 accepted -> pc=00400004, misalign pulses for exactly one cycle.
REQ-039 pc=FFFFFFFC acked with no redirect -> next imem_addr=00000000; rst_n low mid-wait -> imem_req=0 the same cycle, pc=BFC00000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter and instruction-fetch sequencer.
//               Holds the PC and issues one fetch request at a time to
//               instruction memory. Handles jump/branch redirects, which are
//               deferred while a request is outstanding.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               stall                      - gates issue of a new request
//               jump_en/jump_target        - jump redirect (highest priority)
//               branch_en/branch_target    - branch-taken redirect
//               imem_req/imem_addr/imem_ack- instruction memory handshake
//               pc, pc_plus4               - current PC and PC + 4
//               inst_valid, fetch_pc       - completed-fetch pulse and address
//               misalign                   - redirect target had bits[1:0]!=0
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic [31:0] fetch_pc,
    output logic        misalign
);

    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_idle = 2'd1;
    localparam logic [1:0] c_st_req  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_inst_valid;
    logic        r_misalign;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    logic        w_redir_valid;
    logic [31:0] w_redir_raw;
    logic [31:0] w_redir_target;
    logic        w_redir_mis;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    // Same-cycle redirect: jump wins over branch. Targets are word-aligned
    // on load; the discarded low bits only feed the misalign flag.
    assign w_redir_valid  = jump_en | branch_en;
    assign w_redir_raw    = jump_en ? jump_target : branch_target;
    assign w_redir_target = {w_redir_raw[31:2], 2'b00};
    assign w_redir_mis    = w_redir_valid & (|w_redir_raw[1:0]);

    assign w_pc_plus4 = r_pc + 32'd4;

    // PC loaded on an ack edge: a live redirect overrides the pending one,
    // which overrides sequential flow.
    assign w_next_pc = w_redir_valid ? w_redir_target :
                       r_pend_valid  ? r_pend_target  : w_pc_plus4;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Stall only gates entry into REQ; an outstanding
    // request always runs to its ack.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_boot: w_state_nxt = stall ? c_st_idle : c_st_req;
            c_st_idle: if (!stall) w_state_nxt = c_st_req;
            c_st_req:  if (imem_ack) w_state_nxt = stall ? c_st_idle : c_st_req;
            default:   w_state_nxt = c_st_boot;
        endcase
    end

    // ------------------------------------------------------------------
    // PC, pending redirect and fetch-completion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_inst_valid  <= 1'b0;
            r_misalign    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else begin
            r_inst_valid <= 1'b0;
            // Every redirect is accepted in the cycle it is presented,
            // whether it is loaded, latched or consumed by an ack.
            r_misalign   <= w_redir_mis;
            if (r_state == c_st_req) begin
                if (imem_ack) begin
                    r_pc         <= w_next_pc;
                    r_fetch_pc   <= r_pc;
                    r_inst_valid <= 1'b1;
                    r_pend_valid <= 1'b0;
                end else if (w_redir_valid) begin
                    // PC must stay put while the request is outstanding,
                    // so the redirect waits here until the ack.
                    r_pend_valid  <= 1'b1;
                    r_pend_target <= w_redir_target;
                end
            end else if (w_redir_valid) begin
                r_pc         <= w_redir_target;
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign imem_req   = (r_state == c_st_req);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign inst_valid = r_inst_valid;
    assign fetch_pc   = r_fetch_pc;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire
